// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and FSM state encodings shared by the alu_seq block.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADDU = 4'b0000,
        OP_ADDS = 4'b0001,
        OP_SUBU = 4'b0010,
        OP_SUBS = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_SHR  = 4'b0111,
        OP_MULU = 4'b1000,
        OP_DIVU = 4'b1001
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Multiply and divide go through the bit-serial datapath.
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: bit-serial shift-add multiplier and restoring divider.
// One bit per cycle for NUMBITS cycles; lo/hi carry the final values
// combinationally during the cycle where done is high.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int NUMBITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               div,
    input  logic [NUMBITS-1:0] a,
    input  logic [NUMBITS-1:0] b,
    output logic               done,
    output logic [NUMBITS-1:0] lo,
    output logic [NUMBITS-1:0] hi
);

    localparam int CNT_W = $clog2(NUMBITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUMBITS - 1);

    logic               active;
    logic               div_q;
    logic [CNT_W-1:0]   cnt;
    logic [NUMBITS-1:0] acc;     // partial product high half / partial remainder
    logic [NUMBITS-1:0] sreg;    // multiplier being consumed / quotient being built
    logic [NUMBITS-1:0] opnd;    // multiplicand / divisor

    logic [NUMBITS:0]   sum;
    logic [NUMBITS:0]   sh;
    logic [NUMBITS:0]   diff;
    logic [NUMBITS-1:0] nxt_acc;
    logic [NUMBITS-1:0] nxt_sreg;

    // One iteration step of either algorithm, selected by the latched op.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        nxt_acc  = acc;
        nxt_sreg = sreg;
        sum      = {1'b0, acc} + (sreg[0] ? {1'b0, opnd} : '0);
        sh       = {acc, sreg[NUMBITS-1]};
        diff     = sh - {1'b0, opnd};
        if (div_q) begin
            if (!diff[NUMBITS]) begin
                nxt_acc  = diff[NUMBITS-1:0];
                nxt_sreg = {sreg[NUMBITS-2:0], 1'b1};
            end else begin
                nxt_acc  = sh[NUMBITS-1:0];
                nxt_sreg = {sreg[NUMBITS-2:0], 1'b0};
            end
        end else begin
            nxt_acc  = sum[NUMBITS:1];
            nxt_sreg = {sum[0], sreg[NUMBITS-1:1]};
        end
    end

    assign done = active && (cnt == LAST);
    assign lo   = nxt_sreg;
    assign hi   = nxt_acc;

    // Load operands on start, then iterate until the counter reaches its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the datapath registers are few plain flops (no memory array), so they are all reset.
            active <= 1'b0;
            div_q  <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            sreg   <= '0;
            opnd   <= '0;
        end else if (start) begin
            active <= 1'b1;
            div_q  <= div;
            cnt    <= '0;
            acc    <= '0;
            sreg   <= a;
            opnd   <= b;
        end else if (active) begin
            acc  <= nxt_acc;
            sreg <= nxt_sreg;
            if (cnt == LAST) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU. Eight single-cycle ops plus
// bit-serial unsigned multiply/divide; results held in output registers.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int NUMBITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic [3:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] result,
    output logic [NUMBITS-1:0] result_hi,
    output logic               carryout,
    output logic               overflow,
    output logic               zero,
    output logic               busy
);

    localparam int MSB = NUMBITS - 1;

    state_e             state;
    logic               mul_q;
    logic               start_iter;
    logic               iter_done;
    logic [NUMBITS-1:0] iter_lo;
    logic [NUMBITS-1:0] iter_hi;

    logic [NUMBITS:0]   sum_u;
    logic [NUMBITS:0]   diff_u;
    logic [NUMBITS-1:0] alu_lo;
    logic [NUMBITS-1:0] alu_hi;
    logic               alu_c;
    logic               alu_v;
    logic               alu_z;

    assign sum_u  = {1'b0, A} + {1'b0, B};
    assign diff_u = {1'b0, A} - {1'b0, B};

    // Divide by zero takes the single-cycle path; other mul/div go serial.
    assign start_iter = (state == ST_IDLE) && in_valid && is_iter_op(opcode)
                        && !((opcode == OP_DIVU) && (B == '0));

    // Single-cycle result and flags for the operands presented at accept.
    always_comb begin
        alu_lo = '0;
        alu_hi = '0;
        alu_c  = 1'b0;
        alu_v  = 1'b0;
        case (opcode)
            OP_ADDU: begin
                alu_lo = sum_u[MSB:0];
                alu_c  = sum_u[NUMBITS];
            end
            OP_ADDS: begin
                alu_lo = sum_u[MSB:0];
                alu_v  = (A[MSB] == B[MSB]) && (sum_u[MSB] != A[MSB]);
            end
            OP_SUBU: begin
                alu_lo = diff_u[MSB:0];
                alu_c  = diff_u[NUMBITS];
            end
            OP_SUBS: begin
                alu_lo = diff_u[MSB:0];
                alu_v  = (A[MSB] != B[MSB]) && (diff_u[MSB] != A[MSB]);
            end
            OP_AND:  alu_lo = A & B;
            OP_OR:   alu_lo = A | B;
            OP_XOR:  alu_lo = A ^ B;
            OP_SHR: begin
                alu_lo = A >> 1;
                alu_c  = A[0];
            end
            OP_DIVU: begin
                alu_lo = '1;
                alu_hi = A;
                alu_v  = 1'b1;
            end
            default: ;
        endcase
        alu_z = (alu_lo == '0) && (alu_hi == '0);
    end

    alu_seq_iter #(.NUMBITS(NUMBITS)) u_iter (
        .clk   (clk),
        .reset (reset),
        .start (start_iter),
        .div   (opcode == OP_DIVU),
        .a     (A),
        .b     (B),
        .done  (iter_done),
        .lo    (iter_lo),
        .hi    (iter_hi)
    );

    // Control FSM with registered handshake, busy and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            mul_q     <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        mul_q    <= (opcode == OP_MULU);
                        if (start_iter) begin
                            state <= ST_CALC;
                            busy  <= 1'b1;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            result    <= alu_lo;
                            result_hi <= alu_hi;
                            carryout  <= alu_c;
                            overflow  <= alu_v;
                            zero      <= alu_z;
                        end
                    end
                end
                ST_CALC: begin
                    if (iter_done) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        result    <= iter_lo;
                        result_hi <= iter_hi;
                        carryout  <= 1'b0;
                        overflow  <= mul_q && (iter_hi != '0);
                        zero      <= (iter_lo == '0) && (iter_hi == '0);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven vectors, hand sequences and randomized checking
// of alu_seq against an arithmetic reference model.
module tb_alu_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [3:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic [N-1:0] result_hi;
    logic         carryout;
    logic         overflow;
    logic         zero;
    logic         busy;

    int errors = 0;
    int checks = 0;

    alu_seq #(.NUMBITS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] lo;
        logic [N-1:0] hi;
        logic         c;
        logic         v;
        logic         z;
        int           lat;
        int           busy_cycles;
    } res_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [3:0]   op;
        logic [N-1:0] lo;
        logic [N-1:0] hi;
        logic         c;
        logic         v;
        logic         z;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model straight from the operation rules, using integer arithmetic.
    function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] op);
        res_t r;
        int ia = int'(a);
        int ib = int'(b);
        int mask = (1 << N) - 1;
        int half = 1 << (N - 1);
        int sa = (ia >= half) ? ia - (1 << N) : ia;
        int sb = (ib >= half) ? ib - (1 << N) : ib;
        int s;
        r.lo = '0; r.hi = '0; r.c = 1'b0; r.v = 1'b0; r.lat = 1; r.busy_cycles = 0;
        case (op)
            4'd0: begin s = ia + ib; r.lo = N'(s & mask); r.c = (s > mask); end
            4'd1: begin s = sa + sb; r.lo = N'(s & mask); r.v = (s > half - 1) || (s < -half); end
            4'd2: begin r.lo = N'((ia - ib) & mask); r.c = (ia < ib); end
            4'd3: begin s = sa - sb; r.lo = N'(s & mask); r.v = (s > half - 1) || (s < -half); end
            4'd4: r.lo = a & b;
            4'd5: r.lo = a | b;
            4'd6: r.lo = a ^ b;
            4'd7: begin r.lo = N'(ia / 2); r.c = (ia % 2) == 1; end
            4'd8: begin
                s = ia * ib;
                r.lo = N'(s & mask);
                r.hi = N'(s >> N);
                r.v = (r.hi != 0);
                r.lat = N + 1;
                r.busy_cycles = N;
            end
            4'd9: begin
                if (ib == 0) begin
                    r.lo = N'(mask); r.hi = a; r.v = 1'b1;
                end else begin
                    r.lo = N'(ia / ib); r.hi = N'(ia % ib);
                    r.lat = N + 1; r.busy_cycles = N;
                end
            end
            default: ;
        endcase
        r.z = (r.lo == 0) && (r.hi == 0);
        return r;
    endfunction

    // Accept one op, measure latency/busy, hold for 'hold' cycles of backpressure, then hand off.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] op,
                          input int hold, output res_t r);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        A = a; B = b; opcode = op; in_valid = 1'b1;
        @(posedge clk); #1;
        r.lat = 1;
        r.busy_cycles = 0;
        while (!out_valid && r.lat < 40) begin
            if (busy) r.busy_cycles++;
            in_valid = 1'($urandom); A = N'($urandom); B = N'($urandom); opcode = 4'($urandom);
            @(posedge clk); #1;
            r.lat++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
        r.lo = result; r.hi = result_hi; r.c = carryout; r.v = overflow; r.z = zero;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom); A = N'($urandom); B = N'($urandom); opcode = 4'($urandom);
            out_ready = 1'b0;
            @(posedge clk); #1;
            check("hold_stable", 32'({result, result_hi, carryout, overflow, zero, out_valid, in_ready}),
                  32'({r.lo, r.hi, r.c, r.v, r.z, 1'b1, 1'b0}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handshake_in_ready_out_valid", 32'({in_ready, out_valid}), 32'b10);
    endtask

    vec_t vecs[17];
    res_t r;
    res_t m;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'hFF, 8'h01, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1};
        vecs[1]  = '{8'h7F, 8'h01, 4'h1, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1};
        vecs[2]  = '{8'h20, 8'hB1, 4'h2, 8'h6F, 8'h00, 1'b1, 1'b0, 1'b0, 1};
        vecs[3]  = '{8'hFF, 8'hFF, 4'h8, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 9};
        vecs[4]  = '{8'hC8, 8'h0B, 4'h9, 8'h12, 8'h02, 1'b0, 1'b0, 1'b0, 9};
        vecs[5]  = '{8'hC8, 8'h00, 4'h9, 8'hFF, 8'hC8, 1'b0, 1'b1, 1'b0, 1};
        vecs[6]  = '{8'h1A, 8'h55, 4'h7, 8'h0D, 8'h00, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{8'h81, 8'h00, 4'h7, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 1};
        vecs[8]  = '{8'h80, 8'h80, 4'h3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1};
        vecs[9]  = '{8'h80, 8'h01, 4'h3, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 1};
        vecs[10] = '{8'hF0, 8'h3C, 4'h4, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1};
        vecs[11] = '{8'hF0, 8'h3C, 4'h5, 8'hFC, 8'h00, 1'b0, 1'b0, 1'b0, 1};
        vecs[12] = '{8'hF0, 8'h3C, 4'h6, 8'hCC, 8'h00, 1'b0, 1'b0, 1'b0, 1};
        vecs[13] = '{8'h55, 8'h77, 4'hC, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1};
        vecs[14] = '{8'h03, 8'h00, 4'h8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 9};
        vecs[15] = '{8'h07, 8'h09, 4'h9, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0, 9};
        vecs[16] = '{8'h80, 8'h80, 4'h1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; opcode = '0;

        // Reset state.
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_results", 32'({result, result_hi}), 32'd0);
        check("rst_flags", 32'({carryout, overflow, zero}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, i % 3, r);
            check($sformatf("vec%0d_result", i), 32'(r.lo), 32'(vecs[i].lo));
            check($sformatf("vec%0d_result_hi", i), 32'(r.hi), 32'(vecs[i].hi));
            check($sformatf("vec%0d_flags_c_v_z", i), 32'({r.c, r.v, r.z}),
                  32'({vecs[i].c, vecs[i].v, vecs[i].z}));
            check($sformatf("vec%0d_latency", i), 32'(r.lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 32'(r.busy_cycles),
                  (vecs[i].lat == N + 1) ? 32'(N) : 32'd0);
        end

        // Backpressure on a multiply: 5 held cycles inside run_op.
        run_op(8'h3C, 8'h0F, 4'h8, 5, r);
        check("bp_mul_result", 32'({r.hi, r.lo}), 32'h0384);

        // Reset three cycles into a multiply.
        A = 8'hFF; B = 8'hFF; opcode = 4'h8; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (N + 2) begin
            @(posedge clk); #1;
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        run_op(8'h1A, 8'hC3, 4'h7, 0, r);
        check("abort_next_op", 32'({r.lo, r.c}), 32'({8'h0D, 1'b0}));

        // Randomized ops against the reference model.
        repeat (200) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            logic [3:0]   rop;
            ra  = N'($urandom);
            rb  = N'($urandom);
            rop = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) rb = '0;
            run_op(ra, rb, rop, $urandom_range(0, 2), r);
            m = model(ra, rb, rop);
            check($sformatf("rand op%0h a%0h b%0h", rop, ra, rb),
                  32'({r.hi, r.lo, r.c, r.v, r.z}), 32'({m.hi, m.lo, m.c, m.v, m.z}));
            check($sformatf("rand_lat op%0h", rop), 32'(r.lat), 32'(m.lat));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle `myalu`. Keeps the eight base operations (add/sub signed and unsigned, AND, OR, XOR, shift-right-by-one) and adds multi-cycle unsigned multiply and unsigned divide. Operands enter on a valid/ready input port; results and flags leave on a registered valid/ready output port. It serves as the lab datapath's execute stage in front of the writeback register.

## Interface
- `NUMBITS`, 8: operand and result width; must be ≥ 2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1: the operand/opcode bundle is valid.
- `in_ready` out 1: the block accepts a bundle this cycle.
- `A` in NUMBITS: first operand.
- `B` in NUMBITS: second operand.
- `opcode` in 4: operation select.
- `out_valid` out 1: the result bundle is valid.
- `out_ready` in 1: the consumer takes the result this cycle.
- `result` in/out: out, NUMBITS: primary result, or the quotient.
- `result_hi` out NUMBITS: high half of the product, or the remainder; 0 for the other ops.
- `carryout` out 1: carry or borrow flag.
- `overflow` out 1: signed-overflow, product-overflow or divide-by-zero flag.
- `zero` out 1: `result` is zero and `result_hi` is zero.
- `busy` out 1: a multi-cycle operation is in flight.

## Operation
- An input handshake occurs when `in_valid` and `in_ready` are both high. A, B and opcode are latched at that edge.
- Opcodes:
  - 0000 unsigned add: carryout = carry out of the MSB; overflow = 0.
  - 0001 signed add: overflow = two's-complement overflow; carryout = 0.
  - 0010 unsigned sub: carryout = borrow (A < B); overflow = 0.
  - 0011 signed sub: overflow = two's-complement overflow; carryout = 0.
  - 0100 AND, 0101 OR, 0110 XOR: carryout = overflow = 0.
  - 0111 logical shift right by 1 of A: carryout = A[0]; overflow = 0.
  - 1000 unsigned multiply: uses shift-add, one bit per cycle. The result is {result_hi, result}. overflow = (result_hi ≠ 0); carryout = 0.
  - 1001 unsigned divide: uses restoring division, one bit per cycle. result = quotient, result_hi = remainder. If B = 0: result = all ones, result_hi = A, overflow = 1, and the operation takes the single-cycle path. carryout = 0.
  - 1010–1111 reserved: result = 0, result_hi = 0, zero = 1, all other flags 0.
- FSM states:
  - IDLE: in_ready = 1. On accept, go to DONE for a single-cycle op, or to CALC for mul/div (except divide-by-zero, which goes to DONE).
  - CALC: busy = 1. An iteration counter runs from 0 to NUMBITS−1. Go to DONE after the last iteration.
  - DONE: out_valid = 1. Outputs are held stable. On out_ready, go to IDLE.
- in_ready is high only in IDLE. There is no overlap between operations.

## Timing
- Reset values: out_valid = 0, busy = 0, result = 0, result_hi = 0, all flags 0, in_ready = 1 (FSM in IDLE), iteration counter = 0.
- Single-cycle ops: out_valid rises on the edge after accept, giving a latency of 1.
- Mul/div: out_valid rises NUMBITS + 1 edges after accept.
- While out_valid = 1 and out_ready = 0, all outputs are held unchanged for any number of cycles.
- The earliest next accept is the cycle after the output handshake, so the throughput is at most one op every 2 cycles.
- in_valid while in_ready = 0 is ignored. A, B and opcode may change freely outside accept edges.
- Asserting reset during CALC or DONE abandons the operation and drops out_valid immediately (asynchronously). No result is produced.
- All flags are computed from NUMBITS-wide arithmetic. Carry and borrow use a NUMBITS+1-bit internal sum.

## Structure
- Package `alu_seq_pkg` holds:
  - the opcode enum/localparams (OP_ADDU … OP_DIVU);
  - the FSM state encoding (ST_IDLE, ST_CALC, ST_DONE).
- One sub-module, `alu_seq_iter`, holds the shift-add/restoring-divide datapath:
  - accumulator, operand shift registers and counter;
  - ports for start, op select, done, and the two NUMBITS outputs.
- The top level holds the FSM, the single-cycle combinational ALU and the output registers.

## Test plan
- NUMBITS = 8, opcode 0000, A = FF, B = 01 → one cycle after accept: result = 00, zero = 1, carryout = 1, overflow = 0.
- Opcode 0001, A = 7F, B = 01 → result = 80, overflow = 1, carryout = 0. Opcode 0010, A = 20, B = B1 → result = 6F, carryout = 1.
- Opcode 1000, A = FF, B = FF → out_valid 9 cycles after accept: result_hi = FE, result = 01, overflow = 1. busy is high for 8 cycles.
- Opcode 1001, A = C8, B = 0B → result = 12, result_hi = 02, latency 9 cycles. With B = 00 instead → result = FF, result_hi = C8, overflow = 1, latency 1.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid → outputs stay stable and in_ready stays 0. When out_ready rises, in_ready is 1 on the next cycle.
- Assert reset 3 cycles into a multiply → out_valid = 0 and busy = 0 at once. in_ready = 1 after release, and the next accepted op (opcode 0111, A = 1A) returns result = 0D, carryout = 0.
